// File: rtl/sdrc_tgen_pkg.sv
// sdrc_tgen_pkg: shared FSM states, Wishbone CTI codes and LFSR step for the traffic generator
package sdrc_tgen_pkg;
   typedef enum logic [2:0] {IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE} state_t;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_EOB = 3'b111;
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
   endfunction
endpackage

// File: rtl/sdrc_tgen_lfsr.sv
// sdrc_tgen_lfsr: seeded 32-bit Galois LFSR, replicated and truncated to APP_DW
// Ports: clk, rst (sync, active-high), load (reseed), step (advance one state), dat (pattern word)
module sdrc_tgen_lfsr
   import sdrc_tgen_pkg::*;
#(
   parameter int APP_DW = 32,
   parameter logic [31:0] SEED = 32'hACE1_0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [APP_DW-1:0] dat
);
   localparam int REP = (APP_DW + 31) / 32;
   logic [31:0] val;
   logic [REP*32-1:0] rep;
   always_ff @(posedge clk)
      if (rst || load) val <= SEED;
      else if (step) val <= lfsr_next(val);
   assign rep = {REP{val}};
   assign dat = rep[APP_DW-1:0];
endmodule

// File: rtl/sdrc_wb_tgen.sv
// sdrc_wb_tgen: Wishbone burst traffic generator/checker writing and reading back an LFSR pattern
// Ports: wb_clk_i/wb_rst_i clock and sync reset; start/mode/base_addr/num_words/burst_len job setup;
//        wb_* Wishbone master; busy/done/pass/timeout/err_cnt/first_err_addr job status
module sdrc_wb_tgen
   import sdrc_tgen_pkg::*;
#(
   parameter int APP_AW = 26,
   parameter int APP_DW = 32,
   parameter int BL_W = 8,
   parameter logic [31:0] SEED = 32'hACE1_0001,
   parameter int TIMEOUT = 1024
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [APP_AW-1:0]   base_addr,
   input  logic [23:0]         num_words,
   input  logic [BL_W-1:0]     burst_len,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [APP_AW-1:0]   wb_addr_o,
   output logic [APP_DW-1:0]   wb_dat_o,
   output logic [APP_DW/8-1:0] wb_sel_o,
   output logic [2:0]          wb_cti_o,
   input  logic                wb_ack_i,
   input  logic [APP_DW-1:0]   wb_dat_i,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic [15:0]         err_cnt,
   output logic [APP_AW-1:0]   first_err_addr
);
   localparam int SW = APP_DW / 8;
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t state, state_n;
   logic [APP_AW-1:0] addr, base_q;
   logic [23:0] rem, nw_q, src_rem;
   logic [BL_W-1:0] bcnt, bl_q, bl_src, blen;
   logic [1:0] mode_q;
   logic [2:0] cti;
   logic [TW-1:0] wdog;
   logic [APP_DW-1:0] pat;
   logic stb, acc, to_hit, go, rd_start, new_burst;
   assign stb = state == WR_BURST || state == RD_BURST;
   assign acc = stb & wb_ack_i;
   assign to_hit = stb & ~wb_ack_i & (wdog == TW'(TIMEOUT - 1));
   assign go = (state == IDLE || state == DONE) & start;
   // WR_GAP with nothing left means the write phase is over and reads begin
   assign rd_start = state == WR_GAP && rem == 24'd0;
   assign src_rem = go ? num_words : rd_start ? nw_q : rem;
   assign bl_src = go ? (burst_len == '0 ? BL_W'(1) : burst_len) : bl_q;
   assign blen = src_rem < 24'(bl_src) ? src_rem[BL_W-1:0] : bl_src;
   assign new_burst = (state_n == WR_BURST || state_n == RD_BURST) && !stb;
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: if (start) state_n = num_words == 24'd0 ? DONE : mode == 2'b10 ? RD_BURST : WR_BURST;
         WR_BURST: if (to_hit) state_n = DONE;
            else if (acc && bcnt == BL_W'(1)) state_n = rem == 24'd1 && mode_q == 2'b01 ? DONE : WR_GAP;
         WR_GAP: state_n = rem == 24'd0 ? RD_BURST : WR_BURST;
         RD_BURST: if (to_hit) state_n = DONE;
            else if (acc && bcnt == BL_W'(1)) state_n = rem == 24'd1 ? DONE : RD_GAP;
         RD_GAP: state_n = RD_BURST;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i)
      if (wb_rst_i) begin
         state <= IDLE;
         addr <= '0;
         base_q <= '0;
         nw_q <= '0;
         bl_q <= '0;
         mode_q <= '0;
         rem <= '0;
         bcnt <= '0;
         cti <= CTI_CLASSIC;
         wdog <= '0;
         err_cnt <= '0;
         first_err_addr <= '0;
         timeout <= 1'b0;
      end else begin
         state <= state_n;
         wdog <= stb & ~wb_ack_i ? wdog + 1'b1 : '0;
         if (go) begin
            base_q <= base_addr;
            nw_q <= num_words;
            bl_q <= bl_src;
            mode_q <= mode;
            err_cnt <= '0;
            first_err_addr <= '0;
            timeout <= 1'b0;
         end
         if (to_hit) timeout <= 1'b1;
         if (new_burst) begin
            bcnt <= blen;
            rem <= src_rem;
            cti <= blen == BL_W'(1) ? CTI_CLASSIC : CTI_INCR;
            if (go) addr <= base_addr;
            else if (rd_start) addr <= base_q;
         end else if (acc) begin
            addr <= addr + APP_AW'(SW);
            rem <= rem - 24'd1;
            bcnt <= bcnt - BL_W'(1);
            cti <= bcnt == BL_W'(2) ? CTI_EOB : CTI_INCR;
         end
         if (acc && state == RD_BURST && wb_dat_i != pat) begin
            err_cnt <= err_cnt == 16'hFFFF ? err_cnt : err_cnt + 16'd1;
            if (err_cnt == 16'd0) first_err_addr <= addr;
         end
      end
   sdrc_tgen_lfsr #(.APP_DW(APP_DW), .SEED(SEED)) u_lfsr (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .load(go | rd_start),
      .step(acc),
      .dat(pat)
   );
   assign wb_cyc_o = stb;
   assign wb_stb_o = stb;
   assign wb_we_o = state == WR_BURST;
   assign wb_addr_o = addr;
   assign wb_dat_o = wb_we_o ? pat : '0;
   assign wb_sel_o = {SW{stb}};
   assign wb_cti_o = stb ? cti : CTI_CLASSIC;
   assign busy = state != IDLE && state != DONE;
   assign done = state == DONE;
   assign pass = done & ~timeout & (err_cnt == 16'd0);
endmodule

// File: tb/tb_sdrc_wb_tgen.sv
// tb_sdrc_wb_tgen: directed bench for sdrc_wb_tgen against a zero-wait Wishbone memory model
module tb_sdrc_wb_tgen;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [25:0] base_addr = '0;
   logic [23:0] num_words = '0;
   logic [7:0] burst_len = '0;
   logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [25:0] wb_addr_o;
   logic [31:0] wb_dat_o, wb_dat_i;
   logic [3:0] wb_sel_o;
   logic [2:0] wb_cti_o;
   logic busy, done, pass, timeout;
   logic [15:0] err_cnt;
   logic [25:0] first_err_addr;
   logic ack_en = 1'b1, corrupt_en = 1'b0;
   logic [25:0] corrupt_addr = '0;
   logic [31:0] mem [0:255];
   typedef struct {logic we; logic [25:0] addr; logic [31:0] dat; logic [2:0] cti; int cyc;} beat_t;
   beat_t blog[$];
   int ncyc = 0, busy_cnt = 0, cyc_cnt = 0, checks = 0, errors = 0;
   logic first_cyc, first_busy;

   sdrc_wb_tgen dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mode(mode), .base_addr(base_addr),
      .num_words(num_words), .burst_len(burst_len), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;
   assign wb_ack_i = ack_en & wb_stb_o;
   assign wb_dat_i = mem[wb_addr_o[9:2]] ^ {31'b0, corrupt_en && wb_addr_o == corrupt_addr};

   always @(negedge clk) begin
      ncyc++;
      if (wb_stb_o && wb_ack_i) begin
         blog.push_back('{wb_we_o, wb_addr_o, wb_we_o ? wb_dat_o : wb_dat_i, wb_cti_o, ncyc});
         if (wb_we_o) mem[wb_addr_o[9:2]] = wb_dat_o;
      end
      if (busy) busy_cnt++;
      if (wb_cyc_o) cyc_cnt++;
   end

   function automatic logic [31:0] ref_next(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
   endfunction

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic run(input logic [1:0] m, input logic [25:0] b, input logic [23:0] n, input logic [7:0] bl);
      int cycles;
      blog.delete();
      busy_cnt = 0;
      cyc_cnt = 0;
      mode = m;
      base_addr = b;
      num_words = n;
      burst_len = bl;
      start = 1'b1;
      tick;
      start = 1'b0;
      first_cyc = wb_cyc_o;
      first_busy = busy;
      cycles = 0;
      while (!done && cycles < 5000) begin
         tick;
         cycles++;
      end
      if (!done) begin errors++; $display("FAIL run_done_wait: done=%b after %0d cycles, required 1", done, cycles); end
      checks++;
   endtask

   task automatic test_reset;
      repeat (3) tick;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, busy, done, pass, timeout} !== 7'b0) begin
         errors++; $display("FAIL reset_flags: cyc/stb/we/busy/done/pass/timeout=%b required 0000000",
                             {wb_cyc_o, wb_stb_o, wb_we_o, busy, done, pass, timeout});
      end
      checks++;
      if ({err_cnt, first_err_addr, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== '0) begin
         errors++; $display("FAIL reset_values: err=%h fea=%h addr=%h dat=%h sel=%h cti=%b required all 0",
                             err_cnt, first_err_addr, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o);
      end
      checks++;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      logic [31:0] e;
      logic [25:0] ea;
      logic [2:0] ec;
      int k, d;
      run(2'b00, 26'h100, 24'd16, 8'd4);
      if ({first_cyc, first_busy} !== 2'b11) begin
         errors++; $display("FAIL basic_start_latency: cyc,busy=%b required 11", {first_cyc, first_busy});
      end
      checks++;
      if (blog.size() !== 32) begin errors++; $display("FAIL basic_beats: got %0d required 32", blog.size()); end
      checks++;
      e = 32'hACE1_0001;
      for (int i = 0; i < 32 && i < blog.size(); i++) begin
         k = i % 16;
         if (k == 0) e = 32'hACE1_0001;
         ea = 26'h100 + 26'(4 * k);
         ec = (i % 4 == 3) ? 3'b111 : 3'b010;
         if ({blog[i].we, blog[i].addr, blog[i].cti, blog[i].dat} !== {i < 16, ea, ec, e}) begin
            errors++; $display("FAIL basic_beat%0d: got we=%b addr=%h cti=%b dat=%h required we=%b addr=%h cti=%b dat=%h",
                                i, blog[i].we, blog[i].addr, blog[i].cti, blog[i].dat, i < 16, ea, ec, e);
         end
         checks++;
         if (i > 0) begin
            d = (i % 4 == 0) ? 2 : 1;
            if (blog[i].cyc - blog[i-1].cyc != d) begin
               errors++; $display("FAIL basic_spacing%0d: got %0d cycles required %0d", i, blog[i].cyc - blog[i-1].cyc, d);
            end
            checks++;
         end
         e = ref_next(e);
      end
      if (blog.size() > 1 && {blog[0].dat, blog[1].dat} !== {32'hACE1_0001, 32'hD650_8003}) begin
         errors++; $display("FAIL basic_pattern: got %h %h required acе10001 d6508003", blog[0].dat, blog[1].dat);
      end
      checks++;
      if (busy_cnt !== 39) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 39", busy_cnt); end
      checks++;
      if ({done, pass, busy, timeout, err_cnt} !== {4'b1100, 16'd0}) begin
         errors++; $display("FAIL basic_status: done/pass/busy/timeout=%b err=%0d required 1100 err=0",
                             {done, pass, busy, timeout}, err_cnt);
      end
      checks++;
   endtask

   task automatic test_partial_burst;
      run(2'b00, 26'h100, 24'd10, 8'd4);
      if (blog.size() !== 20) begin errors++; $display("FAIL partial_beats: got %0d required 20", blog.size()); end
      checks++;
      if (blog.size() == 20) begin
         if ({blog[9].we, blog[9].addr, blog[9].cti} !== {1'b1, 26'h124, 3'b111}) begin
            errors++; $display("FAIL partial_last_write: got we=%b addr=%h cti=%b required 1 124 111",
                                blog[9].we, blog[9].addr, blog[9].cti);
         end
         checks++;
         if ({blog[3].cti, blog[7].cti, blog[8].cti, blog[10].we} !== {3'b111, 3'b111, 3'b010, 1'b0}) begin
            errors++; $display("FAIL partial_cti: got %b %b %b we10=%b required 111 111 010 0",
                                blog[3].cti, blog[7].cti, blog[8].cti, blog[10].we);
         end
         checks++;
      end
      if (busy_cnt !== 25) begin errors++; $display("FAIL partial_busy_cycles: got %0d required 25", busy_cnt); end
      checks++;
      if ({done, pass} !== 2'b11) begin errors++; $display("FAIL partial_status: done,pass=%b required 11", {done, pass}); end
      checks++;
   endtask

   task automatic test_corrupt;
      corrupt_en = 1'b1;
      corrupt_addr = 26'h114;
      run(2'b00, 26'h100, 24'd16, 8'd4);
      corrupt_en = 1'b0;
      if (err_cnt !== 16'd1) begin errors++; $display("FAIL corrupt_err_cnt: got %0d required 1", err_cnt); end
      checks++;
      if (first_err_addr !== 26'h114) begin errors++; $display("FAIL corrupt_first_addr: got %h required 114", first_err_addr); end
      checks++;
      if ({done, pass, timeout} !== 3'b100) begin
         errors++; $display("FAIL corrupt_status: done,pass,timeout=%b required 100", {done, pass, timeout});
      end
      checks++;
   endtask

   task automatic test_read_only;
      run(2'b10, 26'h100, 24'd16, 8'd4);
      if (blog.size() !== 16 || blog[0].we !== 1'b0 || blog[15].we !== 1'b0) begin
         errors++; $display("FAIL readonly_beats: got %0d beats required 16 reads", blog.size());
      end
      checks++;
      if ({done, pass, err_cnt} !== {2'b11, 16'd0} || busy_cnt !== 19) begin
         errors++; $display("FAIL readonly_status: done,pass=%b err=%0d busy=%0d required 11 0 19",
                             {done, pass}, err_cnt, busy_cnt);
      end
      checks++;
   endtask

   task automatic test_single_beat;
      for (int r = 0; r < 2; r++) begin
         run(2'b01, 26'h40, 24'd3, r == 0 ? 8'd1 : 8'd0);
         if (blog.size() !== 3) begin
            errors++; $display("FAIL single_beats_bl%0d: got %0d required 3", 1 - r, blog.size());
         end
         checks++;
         for (int i = 0; i < 3 && i < blog.size(); i++) begin
            if ({blog[i].we, blog[i].cti, blog[i].addr} !== {1'b1, 3'b000, 26'h40 + 26'(4 * i)}) begin
               errors++; $display("FAIL single_beat%0d_bl%0d: got we=%b cti=%b addr=%h required 1 000 %h",
                                   i, 1 - r, blog[i].we, blog[i].cti, blog[i].addr, 26'h40 + 26'(4 * i));
            end
            checks++;
         end
         if ({done, pass} !== 2'b11) begin errors++; $display("FAIL single_status: done,pass=%b required 11", {done, pass}); end
         checks++;
      end
   endtask

   task automatic test_zero_words;
      run(2'b00, 26'h100, 24'd0, 8'd4);
      if ({done, pass, first_busy} !== 3'b110 || blog.size() !== 0 || busy_cnt !== 0) begin
         errors++; $display("FAIL zero_words: done,pass,busy=%b beats=%0d busy_cycles=%0d required 110 0 0",
                             {done, pass, first_busy}, blog.size(), busy_cnt);
      end
      checks++;
   endtask

   task automatic test_timeout;
      ack_en = 1'b0;
      run(2'b01, 26'h100, 24'd4, 8'd4);
      ack_en = 1'b1;
      if (cyc_cnt !== 1024) begin errors++; $display("FAIL timeout_cyc_cycles: got %0d required 1024", cyc_cnt); end
      checks++;
      if ({timeout, done, pass, busy, wb_cyc_o} !== 5'b11000) begin
         errors++; $display("FAIL timeout_status: timeout,done,pass,busy,cyc=%b required 11000",
                             {timeout, done, pass, busy, wb_cyc_o});
      end
      checks++;
   endtask

   task automatic test_reset_mid_burst;
      int n;
      blog.delete();
      mode = 2'b00;
      base_addr = 26'h100;
      num_words = 24'd16;
      burst_len = 8'd4;
      start = 1'b1;
      tick;
      start = 1'b0;
      n = 0;
      while (blog.size() < 1 && n < 20) begin tick; n++; end
      if ({blog.size() == 1, wb_stb_o} !== 2'b11) begin
         errors++; $display("FAIL midreset_setup: beats=%0d stb=%b required 1 1", blog.size(), wb_stb_o);
      end
      checks++;
      rst = 1'b1;
      tick;
      if ({wb_cyc_o, wb_stb_o, busy, done, err_cnt} !== '0) begin
         errors++; $display("FAIL midreset_outputs: cyc,stb,busy,done=%b err=%0d required 0000 0",
                             {wb_cyc_o, wb_stb_o, busy, done}, err_cnt);
      end
      checks++;
      repeat (4) tick;
      if (blog.size() !== 2) begin errors++; $display("FAIL midreset_no_beats: got %0d beats required 2", blog.size()); end
      checks++;
      rst = 1'b0;
      tick;
      run(2'b00, 26'h100, 24'd16, 8'd4);
      if ({done, pass, err_cnt} !== {2'b11, 16'd0} || blog.size() !== 32) begin
         errors++; $display("FAIL midreset_rerun: done,pass=%b err=%0d beats=%0d required 11 0 32",
                             {done, pass}, err_cnt, blog.size());
      end
      checks++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset;
      test_basic;
      test_partial_burst;
      test_corrupt;
      test_read_only;
      test_single_beat;
      test_zero_words;
      test_timeout;
      test_reset_mid_burst;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
